// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer DMA bus logic: AHB transfer codes,
// arbiter FSM states and the two-port winner selection.
package buzzer_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam int         NUM_PORTS     = 2;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    // One-hot winner among the candidate ports. On a tie, fixed mode always
    // picks Sound (port 1); alternating mode picks the port that did not win
    // the previous tie.
    function automatic logic [1:0] pick_winner(
        input logic [1:0] cand,
        input logic       round_robin,
        input logic       last_ptr
    );
        logic [1:0] win;
        win = cand;
        if (cand == 2'b11) begin
            if (!round_robin) begin
                win = 2'b10;
            end else begin
                win = last_ptr ? 2'b01 : 2'b10;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/bdma_ahb_arbiter_if.sv
// Bus bundle around the buzzer arbiter: two requester slave ports (BGM, Sound)
// and the shared AHB-Lite read master port.
interface bdma_ahb_arbiter_if;

    logic [31:0] b_haddr;
    logic [1:0]  b_htrans;
    logic [31:0] b_hrdata;
    logic        b_hready;

    logic [31:0] s_haddr;
    logic [1:0]  s_htrans;
    logic [31:0] s_hrdata;
    logic        s_hready;

    logic [31:0] m_haddr;
    logic [1:0]  m_htrans;
    logic        m_hwrite;
    logic [31:0] m_hrdata;
    logic        m_hready;

    logic [1:0]  grant;
    logic        busy;

    // Arbiter side of the bundle.
    modport master (
        input  b_haddr, b_htrans, s_haddr, s_htrans, m_hrdata, m_hready,
        output b_hrdata, b_hready, s_hrdata, s_hready,
        output m_haddr, m_htrans, m_hwrite, grant, busy
    );

    // Environment side: the two DMA engines plus the bus matrix.
    modport slave (
        output b_haddr, b_htrans, s_haddr, s_htrans, m_hrdata, m_hready,
        input  b_hrdata, b_hready, s_hrdata, s_hready,
        input  m_haddr, m_htrans, m_hwrite, grant, busy
    );

endinterface

// File: rtl/bdma_ahb_arbiter.sv
// Serialises single reads from the BGM (port 0) and Sound (port 1) DMA engines
// onto one shared AHB-Lite read master, one outstanding transfer at a time.
module bdma_ahb_arbiter
    import buzzer_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bdma_ahb_arbiter_if.master    bus
);

    arb_state_e  state_reg, state_next;
    logic [1:0]  grant_reg, grant_next;
    logic        ptr_reg, ptr_next;
    logic [31:0] m_haddr_reg, m_haddr_next;
    logic [1:0]  m_htrans_reg, m_htrans_next;
    logic        busy_int;

    logic [31:0] haddr      [NUM_PORTS];
    logic [31:0] addr_reg   [NUM_PORTS];
    logic [31:0] addr_next  [NUM_PORTS];
    logic [31:0] hrdata_int [NUM_PORTS];
    logic [1:0]  req_on;
    logic [1:0]  pend_reg, pend_next;
    logic [1:0]  capture, complete, hready_int;

    logic        arb_now;
    logic [1:0]  cand, winner;
    logic        unused_htrans;

    assign haddr[0] = bus.b_haddr;
    assign haddr[1] = bus.s_haddr;
    assign req_on   = {bus.s_htrans[1], bus.b_htrans[1]};
    assign unused_htrans = bus.b_htrans[0] ^ bus.s_htrans[0];

    // Per-port request capture and pending tracking.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic        pend_bit_reg;
            logic [31:0] addr_bit_reg;

            assign complete[gi]   = (state_reg == ARB_DATA) && bus.m_hready && grant_reg[gi];
            assign hready_int[gi] = !pend_bit_reg || complete[gi];
            assign capture[gi]    = req_on[gi] && hready_int[gi];
            assign pend_next[gi]  = capture[gi] || (pend_bit_reg && !complete[gi]);
            assign addr_next[gi]  = capture[gi] ? haddr[gi] : addr_bit_reg;
            assign hrdata_int[gi] = complete[gi] ? bus.m_hrdata : 32'h0;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pend_bit_reg <= 1'b0;
                    addr_bit_reg <= 32'h0;
                end else begin
                    pend_bit_reg <= pend_next[gi];
                    addr_bit_reg <= addr_next[gi];
                end
            end

            assign pend_reg[gi] = pend_bit_reg;
            assign addr_reg[gi] = addr_bit_reg;
        end
    endgenerate

    // State register together with the registered master-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ARB_IDLE;
            grant_reg    <= 2'b00;
            ptr_reg      <= 1'b0;
            m_haddr_reg  <= 32'h0;
            m_htrans_reg <= HTRANS_IDLE;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            ptr_reg      <= ptr_next;
            m_haddr_reg  <= m_haddr_next;
            m_htrans_reg <= m_htrans_next;
        end
    end

    // Next state and arbitration. A port completing this cycle is excluded
    // from the candidates so a back-to-back request cannot jump ahead of a
    // waiting peer; requests arriving this cycle are already eligible.
    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        ptr_next     = ptr_reg;
        m_haddr_next = m_haddr_reg;
        arb_now      = 1'b0;
        cand         = 2'b00;

        case (state_reg)
            ARB_IDLE: begin
                arb_now = 1'b1;
                cand    = pend_reg | capture;
            end
            ARB_ADDR: begin
                state_next = ARB_DATA;
            end
            ARB_DATA: begin
                if (bus.m_hready) begin
                    arb_now = 1'b1;
                    cand    = (pend_reg | capture) & ~grant_reg;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase

        winner = pick_winner(cand, ROUND_ROBIN, ptr_reg);

        if (arb_now) begin
            if (cand != 2'b00) begin
                state_next   = ARB_ADDR;
                grant_next   = winner;
                m_haddr_next = winner[1] ? addr_next[1] : addr_next[0];
                if (cand == 2'b11) begin
                    ptr_next = winner[1];
                end
            end else begin
                state_next = ARB_IDLE;
                grant_next = 2'b00;
            end
        end
    end

    // Output decode.
    always_comb begin
        m_htrans_next = (state_next == ARB_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
        busy_int      = (state_reg != ARB_IDLE);
    end

    assign bus.b_hready = hready_int[0];
    assign bus.s_hready = hready_int[1];
    assign bus.b_hrdata = hrdata_int[0];
    assign bus.s_hrdata = hrdata_int[1];
    assign bus.m_haddr  = m_haddr_reg;
    assign bus.m_htrans = m_htrans_reg;
    assign bus.m_hwrite = 1'b0;
    assign bus.grant    = grant_reg;
    assign bus.busy     = busy_int;

endmodule

// File: tb/tb_bdma_ahb_arbiter.sv
// Bench for bdma_ahb_arbiter: directed vector tables on a fixed-priority and an
// alternating instance, then randomized traffic against a transaction model.
module tb_bdma_ahb_arbiter;

    localparam logic [31:0] J = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] b_haddr, s_haddr;
    logic [1:0]  b_htrans, s_htrans;
    logic        m_hready_i [2];
    logic [31:0] m_hrdata_i [2];

    bdma_ahb_arbiter_if bus0 ();
    bdma_ahb_arbiter_if bus1 ();

    assign bus0.b_haddr  = b_haddr;
    assign bus0.b_htrans = b_htrans;
    assign bus0.s_haddr  = s_haddr;
    assign bus0.s_htrans = s_htrans;
    assign bus0.m_hready = m_hready_i[0];
    assign bus0.m_hrdata = m_hrdata_i[0];
    assign bus1.b_haddr  = b_haddr;
    assign bus1.b_htrans = b_htrans;
    assign bus1.s_haddr  = s_haddr;
    assign bus1.s_htrans = s_htrans;
    assign bus1.m_hready = m_hready_i[1];
    assign bus1.m_hrdata = m_hrdata_i[1];

    bdma_ahb_arbiter #(.ROUND_ROBIN(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    bdma_ahb_arbiter #(.ROUND_ROBIN(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // Outputs of both instances, indexed [dut][port].
    logic        hr_o [2][2];
    logic [31:0] hd_o [2][2];
    logic [31:0] ma_o [2];
    logic [1:0]  mt_o [2];
    logic [1:0]  g_o  [2];
    logic        busy_o [2];
    logic        mw_o [2];

    assign hr_o[0][0] = bus0.b_hready;  assign hr_o[0][1] = bus0.s_hready;
    assign hd_o[0][0] = bus0.b_hrdata;  assign hd_o[0][1] = bus0.s_hrdata;
    assign hr_o[1][0] = bus1.b_hready;  assign hr_o[1][1] = bus1.s_hready;
    assign hd_o[1][0] = bus1.b_hrdata;  assign hd_o[1][1] = bus1.s_hrdata;
    assign ma_o[0] = bus0.m_haddr;   assign ma_o[1] = bus1.m_haddr;
    assign mt_o[0] = bus0.m_htrans;  assign mt_o[1] = bus1.m_htrans;
    assign g_o[0]  = bus0.grant;     assign g_o[1]  = bus1.grant;
    assign busy_o[0] = bus0.busy;    assign busy_o[1] = bus1.busy;
    assign mw_o[0] = bus0.m_hwrite;  assign mw_o[1] = bus1.m_hwrite;

    int vectors;
    int miscompares;

    typedef struct {
        int          grp;
        int          k;
        string       name;
        logic        rs;
        logic        bt;
        logic [31:0] ba;
        logic        st;
        logic [31:0] sa;
        logic        mr;
        logic [31:0] md;
        logic        e_bh;
        logic [31:0] e_bd;
        logic        e_sh;
        logic [31:0] e_sd;
        logic        e_ns;
        logic [31:0] e_ma;
        logic [1:0]  e_g;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input int grp, input int k, input string name, input logic rs,
                     input logic bt, input logic [31:0] ba, input logic st, input logic [31:0] sa,
                     input logic mr, input logic [31:0] md,
                     input logic e_bh, input logic [31:0] e_bd, input logic e_sh, input logic [31:0] e_sd,
                     input logic e_ns, input logic [31:0] e_ma, input logic [1:0] e_g, input logic e_busy);
        vec_t t;
        t.grp = grp; t.k = k; t.name = name; t.rs = rs;
        t.bt = bt; t.ba = ba; t.st = st; t.sa = sa; t.mr = mr; t.md = md;
        t.e_bh = e_bh; t.e_bd = e_bd; t.e_sh = e_sh; t.e_sd = e_sd;
        t.e_ns = e_ns; t.e_ma = e_ma; t.e_g = e_g; t.e_busy = e_busy;
        tbl.push_back(t);
    endtask

    // Simultaneous request pair: winner served in cycles 1-2, loser in 3-4.
    task automatic pair(input int grp, input int k, input logic sound_first,
                        input logic [31:0] ba, input logic [31:0] sa);
        logic [31:0] bd, sd;
        bd = ba ^ 32'hA5A5_0000;
        sd = sa ^ 32'h5A5A_0000;
        v(grp, k, "pair_req", 0, 1, ba, 1, sa, 1, J, 1, 0, 1, 0, 0, 0, 2'b00, 0);
        if (sound_first) begin
            v(grp, k, "pair_s_addr", 0, 0, 0, 0, 0, 1, J,  0, 0, 0, 0,  1, sa, 2'b10, 1);
            v(grp, k, "pair_s_data", 0, 0, 0, 0, 0, 1, sd, 0, 0, 1, sd, 0, 0,  2'b10, 1);
            v(grp, k, "pair_b_addr", 0, 0, 0, 0, 0, 1, J,  0, 0, 1, 0,  1, ba, 2'b01, 1);
            v(grp, k, "pair_b_data", 0, 0, 0, 0, 0, 1, bd, 1, bd, 1, 0, 0, 0,  2'b01, 1);
        end else begin
            v(grp, k, "pair_b_addr", 0, 0, 0, 0, 0, 1, J,  0, 0, 0, 0,  1, ba, 2'b01, 1);
            v(grp, k, "pair_b_data", 0, 0, 0, 0, 0, 1, bd, 1, bd, 0, 0, 0, 0,  2'b01, 1);
            v(grp, k, "pair_s_addr", 0, 0, 0, 0, 0, 1, J,  1, 0, 0, 0,  1, sa, 2'b10, 1);
            v(grp, k, "pair_s_data", 0, 0, 0, 0, 0, 1, sd, 1, 0, 1, sd, 0, 0,  2'b10, 1);
        end
    endtask

    task automatic idle_vec(input int grp, input int k);
        v(grp, k, "idle", 0, 0, 0, 0, 0, 1, J, 1, 0, 1, 0, 0, 0, 2'b00, 0);
    endtask

    task automatic check(input string name, input int k,
                         input logic e_bh, input logic [31:0] e_bd, input logic e_sh, input logic [31:0] e_sd,
                         input logic e_ns, input logic chk_ma, input logic [31:0] e_ma,
                         input logic [1:0] e_g, input logic e_busy);
        logic [1:0] e_mt;
        logic       bad;
        e_mt = e_ns ? 2'b10 : 2'b00;
        bad = (hr_o[k][0] !== e_bh) || (hd_o[k][0] !== e_bd) ||
              (hr_o[k][1] !== e_sh) || (hd_o[k][1] !== e_sd) ||
              (mt_o[k] !== e_mt) || (chk_ma && (ma_o[k] !== e_ma)) ||
              (g_o[k] !== e_g) || (busy_o[k] !== e_busy) || (mw_o[k] !== 1'b0);
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL %s dut%0d: got bh=%b bd=%h sh=%b sd=%h mt=%b ma=%h g=%b busy=%b hw=%b; expected bh=%b bd=%h sh=%b sd=%h mt=%b ma=%h g=%b busy=%b",
                     name, k, hr_o[k][0], hd_o[k][0], hr_o[k][1], hd_o[k][1], mt_o[k], ma_o[k],
                     g_o[k], busy_o[k], mw_o[k], e_bh, e_bd, e_sh, e_sd, e_mt, e_ma, e_g, e_busy);
        end else begin
            $display("vec %s dut%0d ok: bh=%b bd=%h sh=%b sd=%h mt=%b g=%b", name, k,
                     hr_o[k][0], hd_o[k][0], hr_o[k][1], hd_o[k][1], mt_o[k], g_o[k]);
        end
    endtask

    task automatic drive_idle();
        b_htrans = 2'b00; s_htrans = 2'b00; b_haddr = 32'h0; s_haddr = 32'h0;
        for (int k = 0; k < 2; k++) begin
            m_hready_i[k] = 1'b1;
            m_hrdata_i[k] = J;
        end
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) check("reset", k, 1, 0, 1, 0, 0, 1, 32'h0, 2'b00, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic apply(input vec_t t);
        @(posedge clk);
        #1;
        rst_n    = !t.rs;
        b_htrans = t.bt ? 2'b10 : 2'b00;
        b_haddr  = t.ba;
        s_htrans = t.st ? 2'b10 : 2'b00;
        s_haddr  = t.sa;
        for (int k = 0; k < 2; k++) begin
            m_hready_i[k] = t.mr;
            m_hrdata_i[k] = t.md;
        end
        #1;
        check(t.name, t.k, t.e_bh, t.e_bd, t.e_sh, t.e_sd, t.e_ns, t.e_ns | t.rs, t.e_ma, t.e_g, t.e_busy);
    endtask

    // Slave data pattern: any address maps to a distinct word.
    function automatic logic [31:0] fdat(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0F0F_F0F0;
    endfunction

    // Transaction-level model state for the random phase, per DUT and port.
    bit          pend_m  [2][2];
    bit          issued  [2][2];
    logic [31:0] addr_m  [2][2];
    int          age     [2][2];
    bit          sl_in   [2];
    logic [31:0] sl_addr [2];
    int          owner   [2];

    task automatic random_phase(input int ncycles);
        for (int k = 0; k < 2; k++) begin
            sl_in[k] = 0; sl_addr[k] = 0; owner[k] = 0;
            for (int x = 0; x < 2; x++) begin
                pend_m[k][x] = 0; issued[k][x] = 0; addr_m[k][x] = 0; age[k][x] = 0;
            end
        end
        for (int c = 0; c < ncycles; c++) begin
            @(posedge clk);
            #1;
            b_htrans = ($urandom_range(0, 99) < 35) ? 2'b10 : {1'b0, 1'($urandom_range(0, 1))};
            s_htrans = ($urandom_range(0, 99) < 35) ? 2'b10 : {1'b0, 1'($urandom_range(0, 1))};
            b_haddr  = $urandom;
            s_haddr  = $urandom;
            for (int k = 0; k < 2; k++) begin
                if (sl_in[k]) begin
                    m_hready_i[k] = ($urandom_range(0, 2) != 0);
                    m_hrdata_i[k] = m_hready_i[k] ? fdat(sl_addr[k]) : $urandom;
                end else begin
                    m_hready_i[k] = 1'b1;
                    m_hrdata_i[k] = $urandom;
                end
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                bit          ok;
                bit          comp [2];
                bit          exp_h [2];
                logic [31:0] exp_d [2];
                bit          ns;
                bit          exp_busy;
                int          p;
                ok = 1;
                for (int x = 0; x < 2; x++) begin
                    comp[x]  = pend_m[k][x] && issued[k][x] && sl_in[k] && m_hready_i[k] && (owner[k] == x);
                    exp_h[x] = !pend_m[k][x] || comp[x];
                    exp_d[x] = comp[x] ? fdat(addr_m[k][x]) : 32'h0;
                    if (hr_o[k][x] !== exp_h[x] || hd_o[k][x] !== exp_d[x]) ok = 0;
                    if (pend_m[k][x] && age[k][x] > 64) ok = 0;
                end
                ns = (mt_o[k] == 2'b10);
                if (mt_o[k] !== 2'b00 && mt_o[k] !== 2'b10) ok = 0;
                if (mw_o[k] !== 1'b0) ok = 0;
                exp_busy = sl_in[k] || ns;
                if (busy_o[k] !== exp_busy) ok = 0;
                if (!exp_busy && g_o[k] !== 2'b00) ok = 0;
                if (sl_in[k] && g_o[k] !== (owner[k] == 1 ? 2'b10 : 2'b01)) ok = 0;
                if (sl_in[k] && ns) ok = 0;
                p = -1;
                if (ns) begin
                    p = (g_o[k] == 2'b01) ? 0 : (g_o[k] == 2'b10) ? 1 : -1;
                    if (p < 0) ok = 0;
                    else if (!pend_m[k][p] || issued[k][p] || ma_o[k] !== addr_m[k][p]) ok = 0;
                end
                vectors++;
                if (!ok) begin
                    miscompares++;
                    $display("FAIL rand dut%0d cyc%0d: got bh=%b bd=%h sh=%b sd=%h mt=%b ma=%h g=%b busy=%b; expected bh=%b bd=%h sh=%b sd=%h busy=%b",
                             k, c, hr_o[k][0], hd_o[k][0], hr_o[k][1], hd_o[k][1], mt_o[k], ma_o[k],
                             g_o[k], busy_o[k], exp_h[0], exp_d[0], exp_h[1], exp_d[1], exp_busy);
                end
                for (int x = 0; x < 2; x++) begin
                    if (comp[x]) begin
                        pend_m[k][x] = 0; issued[k][x] = 0; sl_in[k] = 0;
                    end
                end
                if (ns && p >= 0) begin
                    sl_in[k] = 1; sl_addr[k] = ma_o[k]; owner[k] = p; issued[k][p] = 1;
                end
                for (int x = 0; x < 2; x++) begin
                    logic        t1;
                    logic [31:0] a;
                    t1 = (x == 0) ? b_htrans[1] : s_htrans[1];
                    a  = (x == 0) ? b_haddr : s_haddr;
                    if (t1 && exp_h[x]) begin
                        pend_m[k][x] = 1; addr_m[k][x] = a; issued[k][x] = 0; age[k][x] = 0;
                    end else if (pend_m[k][x]) begin
                        age[k][x]++;
                    end
                end
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        drive_idle();

        // Single BGM read, zero-wait slave.
        v(1, 0, "single_req",  0, 1, 32'h1000, 0, 0, 1, J,         1, 0,          1, 0, 0, 0,        2'b00, 0);
        v(1, 0, "single_addr", 0, 0, 0,        0, 0, 1, J,         0, 0,          1, 0, 1, 32'h1000, 2'b01, 1);
        v(1, 0, "single_data", 0, 0, 0,        0, 0, 1, 32'h1234,  1, 32'h1234,   1, 0, 0, 0,        2'b01, 1);
        idle_vec(1, 0);

        // Contention: fixed priority, then alternating (three pairs).
        pair(2, 0, 1, 32'h100, 32'h200);
        idle_vec(2, 0);
        pair(3, 1, 1, 32'h104, 32'h204);
        pair(3, 1, 0, 32'h108, 32'h208);
        pair(3, 1, 1, 32'h10C, 32'h20C);
        idle_vec(3, 1);

        // Three slave wait states in the data phase.
        v(4, 0, "wait_req",  0, 1, 32'h2000, 0, 0, 1, J,            1, 0,            1, 0, 0, 0,        2'b00, 0);
        v(4, 0, "wait_addr", 0, 0, 0,        0, 0, 1, J,            0, 0,            1, 0, 1, 32'h2000, 2'b01, 1);
        v(4, 0, "wait_1",    0, 0, 0,        0, 0, 0, J,            0, 0,            1, 0, 0, 0,        2'b01, 1);
        v(4, 0, "wait_2",    0, 0, 0,        0, 0, 0, J,            0, 0,            1, 0, 0, 0,        2'b01, 1);
        v(4, 0, "wait_3",    0, 0, 0,        0, 0, 0, J,            0, 0,            1, 0, 0, 0,        2'b01, 1);
        v(4, 0, "wait_data", 0, 0, 0,        0, 0, 1, 32'hCAFE0001, 1, 32'hCAFE0001, 1, 0, 0, 0,        2'b01, 1);
        idle_vec(4, 0);

        // Back-to-back Sound while BGM waits: BGM goes before Sound's second read.
        v(5, 0, "b2b_s_req",   0, 0, 0,       1, 32'h300, 1, J,            1, 0,            1, 0,            0, 0,       2'b00, 0);
        v(5, 0, "b2b_s_addr",  0, 1, 32'h400, 0, 0,       1, J,            1, 0,            0, 0,            1, 32'h300, 2'b10, 1);
        v(5, 0, "b2b_s_data",  0, 0, 0,       1, 32'h310, 1, 32'h11110300, 0, 0,            1, 32'h11110300, 0, 0,       2'b10, 1);
        v(5, 0, "b2b_b_addr",  0, 0, 0,       0, 0,       1, J,            0, 0,            0, 0,            1, 32'h400, 2'b01, 1);
        v(5, 0, "b2b_b_data",  0, 0, 0,       0, 0,       1, 32'h22220400, 1, 32'h22220400, 0, 0,            0, 0,       2'b01, 1);
        v(5, 0, "b2b_s2_addr", 0, 0, 0,       0, 0,       1, J,            1, 0,            0, 0,            1, 32'h310, 2'b10, 1);
        v(5, 0, "b2b_s2_data", 0, 0, 0,       0, 0,       1, 32'h33330310, 1, 0,            1, 32'h33330310, 0, 0,       2'b10, 1);
        idle_vec(5, 0);

        // Reset asserted during a stalled data phase, then a normal read.
        v(6, 0, "rst_req",    0, 1, 32'h5000, 0, 0, 1, J,            1, 0,            1, 0, 0, 0,        2'b00, 0);
        v(6, 0, "rst_addr",   0, 0, 0,        0, 0, 1, J,            0, 0,            1, 0, 1, 32'h5000, 2'b01, 1);
        v(6, 0, "rst_stall",  0, 0, 0,        0, 0, 0, J,            0, 0,            1, 0, 0, 0,        2'b01, 1);
        v(6, 0, "rst_mid",    1, 0, 0,        0, 0, 0, J,            1, 0,            1, 0, 0, 32'h0,    2'b00, 0);
        v(6, 0, "post_req",   0, 1, 32'h6000, 0, 0, 1, J,            1, 0,            1, 0, 0, 0,        2'b00, 0);
        v(6, 0, "post_addr",  0, 0, 0,        0, 0, 1, J,            0, 0,            1, 0, 1, 32'h6000, 2'b01, 1);
        v(6, 0, "post_data",  0, 0, 0,        0, 0, 1, 32'h66666000, 1, 32'h66666000, 1, 0, 0, 0,        2'b01, 1);
        idle_vec(6, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            if (i == 0 || tbl[i].grp != tbl[i-1].grp) do_reset();
            apply(tbl[i]);
        end

        do_reset();
        random_phase(3000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bdma_ahb_arbiter.md
# bdma_ahb_arbiter

Shares one AHB-Lite read-only master port between the two buzzer DMA engines: the BGM channel (port 0) and the Sound-effect channel (port 1). It sits between the two DMA engines' master ports and the SoC bus matrix. The matrix then needs one buzzer master instead of two. Each requester sees an ordinary AHB-Lite slave with wait states, and the arbiter serialises their single reads onto the shared port.

## Interface
- ROUND_ROBIN, 0: 0 = fixed priority, Sound (port 1) always wins; 1 = alternate on contention.
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- b_haddr  in  32  BGM requester address
- b_htrans  in  2  BGM transfer type; only bit 1 is examined (NONSEQ = request)
- b_hrdata  out  32  BGM read data
- b_hready  out  1  BGM ready
- s_haddr / s_htrans / s_hrdata / s_hready: same as the four BGM ports, for Sound
- m_haddr  out  32  shared master address
- m_htrans  out  2  shared master transfer type, IDLE (2'b00) or NONSEQ (2'b10)
- m_hwrite  out  1  tied 0
- m_hrdata  in  32  shared master read data
- m_hready  in  1  shared master ready
- grant  out  2  one-hot owner of the current shared-port transfer; 0 when idle
- busy  out  1  high while the FSM is not in IDLE

## Operation
- **Capture:** requester x raises a request when x_htrans[1]=1 and x_hready=1. On that edge, x_haddr is latched into addr_q[x] and pend[x] is set.
- **Wait signalling:** x_hready is 0 while pend[x]=1, except in x's completion cycle.
- **Arbitration:** performed when the FSM is in IDLE, or in DATA on its completion cycle, and at least one pend bit is set.
  - ROUND_ROBIN=0: port 1 wins.
  - ROUND_ROBIN=1: the port that was not last granted wins. The last-grant pointer resets to 0, so Sound wins the first tie.
- **FSM states:**
  - IDLE: m_htrans=IDLE. Goes to ADDR if any pend bit is set.
  - ADDR: m_htrans=NONSEQ, m_haddr=addr_q[grant]. Always goes to DATA.
  - DATA: m_htrans=IDLE. Waits for m_hready=1, which is the completion cycle. On completion:
    - x_hrdata = m_hrdata and x_hready = 1 for the granted port;
    - pend[grant] is cleared;
    - next state is ADDR if another pend bit is set, else IDLE.
- **Back-to-back:** a requester may issue a new NONSEQ in its own completion cycle. It is captured because x_hready=1, and pend stays effectively set.
- **Read data:** x_hrdata is 0 except in x's completion cycle.
- **Not cancellable:** a requester deasserting htrans after capture does not cancel its request. This covers a DMA soft reset via its local rst_n. The transfer completes and the returned data is discarded by the requester.
- **Error responses:** m_hresp is not used; all responses are treated as OKAY.

## Timing
- **Reset values:** m_htrans=IDLE, m_haddr=0, m_hwrite=0, b_hready=s_hready=1, b_hrdata=s_hrdata=0, grant=0, busy=0, pend=0, pointer=0.
- **Single zero-wait read:** requester address phase in cycle 0; m address phase in cycle 1; completion in cycle 2. Latency is 2 cycles from requester address phase to data.
- **Slave wait states:** each cycle of m_hready=0 adds one cycle of requester wait.
- **Contention:** the loser's m address phase is the cycle after the winner's completion. With a zero-wait slave, loser data arrives in cycle 4.
- **Reset mid-transfer:** asserting rst_n clears everything immediately, including pend and FSM state. An in-flight m data phase is abandoned.
- **Outstanding transfers:** at most one on m at any time.
- **Registered outputs:** m_haddr and m_htrans. Only x_hready and x_hrdata depend combinationally on m_hready and m_hrdata.

## Structure
- Shared package buzzer_pkg holds:
  - HTRANS_IDLE / HTRANS_NONSEQ constants;
  - the FSM state enum (ARB_IDLE, ARB_ADDR, ARB_DATA).
- Single module; no sub-module. The capture/pend logic is duplicated per port with a generate loop over 2.

## Test plan
- **Single BGM read:** b_haddr=0x0000_1000 NONSEQ in cycle 0, zero-wait slave returning 0x1234 → m_haddr=0x1000 NONSEQ in cycle 1; b_hready=1 and b_hrdata=0x1234 in cycle 2; grant=2'b01.
- **Simultaneous requests, ROUND_ROBIN=0:** BGM addr 0x100, Sound addr 0x200 in the same cycle → Sound served first (completes cycle 2), BGM next (m address cycle 3, completes cycle 4).
- **ROUND_ROBIN=1:** three successive simultaneous request pairs → grant order Sound, BGM, Sound/BGM alternating; no port starves.
- **Slave wait states:** m_hready held low for 3 cycles in DATA → requester hready low for exactly those cycles plus the base latency; data returned unchanged.
- **Back-to-back Sound:** Sound issues a new request in its completion cycle while BGM is pending → BGM is served before Sound's second read.
- **Reset mid-DATA:** rst_n asserted during DATA → all outputs at reset values immediately; after release, a new request is served normally.
